aes_inv_round_ctrl: RTL and testbench

//   Iterative AES decryption engine: sequences one shared inverse-round datapath
//   (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns) over NR rounds, one

---
 rtl/aes_inv_round_ctrl.sv | 148 ++++++++++++++
 tb/tb_aes_inv_round_ctrl.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_round_ctrl.sv
`timescale 1ns/1ps
// Iterative AES inverse cipher: one shared inverse-round datapath reused for NR rounds,
// valid/ready on both sides, round keys fetched from an external store through rk_idx.
module aes_inv_round_ctrl #(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic [3:0]   rk_idx,
   input  logic [127:0] rk,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
);

   localparam logic [3:0] NR_IDX = 4'(NR);

   typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

   fsm_t         fsm, fsm_nxt;
   logic [3:0]   cnt, cnt_nxt;
   logic [127:0] state, state_nxt;
   logic [127:0] out_q, out_nxt;
   logic [127:0] sub_key;
   logic [127:0] mixed;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      logic [7:0] t;
      r = '0;
      t = a;
      for (int unsigned i = 0; i < 8; i++) begin
         if (b[i]) r = r ^ t;
         t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
      end
      return r;
   endfunction

   // Inverse S-box computed as inverse affine map followed by x^254 (the field inverse, 0 -> 0).
   function automatic logic [7:0] inv_sbox(input logic [7:0] x);
      logic [7:0] a;
      logic [7:0] p;
      a = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
      p = a;
      for (int unsigned i = 0; i < 6; i++)
         p = gmul(gmul(p, p), a);
      return gmul(p, p);
   endfunction

   function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int unsigned i = 0; i < 16; i++)
         o[127 - 8*i -: 8] = inv_sbox(s[127 - 8*i -: 8]);
      return o;
   endfunction

   // Byte index is row + 4*column; row r rotates right by r columns.
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int unsigned c = 0; c < 4; c++)
         for (int unsigned r = 0; r < 4; r++)
            o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int unsigned c = 0; c < 4; c++) begin
         a0 = s[127 - 32*c -: 8];
         a1 = s[119 - 32*c -: 8];
         a2 = s[111 - 32*c -: 8];
         a3 = s[103 - 32*c -: 8];
         o[127 - 32*c -: 32] = {
            gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
      end
      return o;
   endfunction

   assign sub_key  = inv_sub_bytes(inv_shift_rows(state)) ^ rk;
   assign mixed    = inv_mix_columns(sub_key);
   assign out_data = out_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm   <= IDLE;
         cnt   <= '0;
         state <= '0;
         out_q <= '0;
      end else begin
         fsm   <= fsm_nxt;
         cnt   <= cnt_nxt;
         state <= state_nxt;
         out_q <= out_nxt;
      end
   end

   // out_q is loaded only by the final round so it stays frozen outside DONE.
   always_comb begin
      fsm_nxt   = fsm;
      cnt_nxt   = cnt;
      state_nxt = state;
      out_nxt   = out_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      rk_idx    = NR_IDX;
      case (fsm)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_nxt = in_data ^ rk;
               cnt_nxt   = NR_IDX - 4'd1;
               fsm_nxt   = ROUND;
            end
         end
         ROUND: begin
            busy   = 1'b1;
            rk_idx = cnt;
            if (cnt != '0) begin
               state_nxt = mixed;
               cnt_nxt   = cnt - 4'd1;
            end else begin
               state_nxt = sub_key;
               out_nxt   = sub_key;
               fsm_nxt   = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) fsm_nxt = IDLE;
         end
         default: fsm_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
`timescale 1ns/1ps
// Directed bench for aes_inv_round_ctrl: FIPS-197 C.1 (NR=10) and C.3 (NR=14) vectors,
// key store modelled by a bench-side key expansion.
module tb_aes_inv_round_ctrl;

   localparam logic [127:0] CT10 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT14 = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic         in_valid10, in_ready10, out_valid10, out_ready10, busy10;
   logic [127:0] in_data10, rk10, out_data10;
   logic [3:0]   rk_idx10;

   logic         in_valid14, in_ready14, out_valid14, out_ready14, busy14;
   logic [127:0] in_data14, rk14, out_data14;
   logic [3:0]   rk_idx14;

   logic [127:0] rks10 [0:15];
   logic [127:0] rks14 [0:15];

   assign rk10 = rks10[rk_idx10];
   assign rk14 = rks14[rk_idx14];

   int checks   = 0;
   int failures = 0;

   aes_inv_round_ctrl #(.NR(10)) u10 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid10), .in_ready(in_ready10), .in_data(in_data10),
      .rk_idx(rk_idx10), .rk(rk10),
      .out_valid(out_valid10), .out_ready(out_ready10), .out_data(out_data10),
      .busy(busy10)
   );

   aes_inv_round_ctrl #(.NR(14)) u14 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid14), .in_ready(in_ready14), .in_data(in_data14),
      .rk_idx(rk_idx14), .rk(rk14),
      .out_valid(out_valid14), .out_ready(out_ready14), .out_data(out_data14),
      .busy(busy14)
   );

   function automatic logic [7:0] xt(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      logic [7:0] t;
      r = 8'h00;
      t = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) r = r ^ t;
         t = xt(t);
      end
      return r;
   endfunction

   function automatic logic [7:0] fsbox(input logic [7:0] x);
      logic [7:0] p;
      p = x;
      for (int i = 0; i < 6; i++) p = gm(gm(p, p), x);
      p = gm(p, p);
      return p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]} ^ {p[3:0], p[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {fsbox(w[31:24]), fsbox(w[23:16]), fsbox(w[15:8]), fsbox(w[7:0])};
   endfunction

   function automatic logic [127:0] round_key(input logic [255:0] key, input int nk, input int r);
      logic [31:0] w [0:59];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 60; i++) w[i] = 32'h0;
      for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
      for (int i = nk; i < 60; i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = xt(rc);
         end else if (nk > 6 && i % nk == 4) begin
            t = sub_word(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({in_ready10, out_valid10, busy10, rk_idx10} !== {1'b1, 1'b0, 1'b0, 4'd10}) begin
         failures++;
         $display("FAIL reset_ctrl10 got=%b exp=%b", {in_ready10, out_valid10, busy10, rk_idx10}, {1'b1, 1'b0, 1'b0, 4'd10});
      end
      checks++;
      if ({in_ready14, out_valid14, busy14, rk_idx14} !== {1'b1, 1'b0, 1'b0, 4'd14}) begin
         failures++;
         $display("FAIL reset_ctrl14 got=%b exp=%b", {in_ready14, out_valid14, busy14, rk_idx14}, {1'b1, 1'b0, 1'b0, 4'd14});
      end
      checks++;
      if ({out_data10, out_data14} !== 256'h0) begin
         failures++;
         $display("FAIL reset_data got=%h exp=0", {out_data10, out_data14});
      end
   endtask

   task automatic test_c1_trace();
      out_ready10 = 1'b0;
      @(negedge clk);
      in_valid10 = 1'b1;
      in_data10  = CT10;
      checks++;
      if ({in_ready10, rk_idx10} !== {1'b1, 4'd10}) begin
         failures++;
         $display("FAIL c1_accept got=%b exp=%b", {in_ready10, rk_idx10}, {1'b1, 4'd10});
      end
      for (int k = 9; k >= 0; k--) begin
         @(negedge clk);
         in_valid10 = 1'b0;
         in_data10  = '0;
         checks++;
         if ({busy10, out_valid10, in_ready10, rk_idx10} !== {1'b1, 1'b0, 1'b0, 4'(k)}) begin
            failures++;
            $display("FAIL c1_round_trace got=%b exp=%b", {busy10, out_valid10, in_ready10, rk_idx10}, {1'b1, 1'b0, 1'b0, 4'(k)});
         end
      end
      @(negedge clk);
      checks++;
      if ({out_valid10, rk_idx10} !== {1'b1, 4'd10}) begin
         failures++;
         $display("FAIL c1_done_ctrl got=%b exp=%b", {out_valid10, rk_idx10}, {1'b1, 4'd10});
      end
      checks++;
      if (out_data10 !== PT) begin
         failures++;
         $display("FAIL c1_plaintext got=%h exp=%h", out_data10, PT);
      end
      out_ready10 = 1'b1;
      @(negedge clk);
      out_ready10 = 1'b0;
      checks++;
      if ({out_valid10, in_ready10, busy10} !== 3'b010) begin
         failures++;
         $display("FAIL c1_release got=%b exp=010", {out_valid10, in_ready10, busy10});
      end
   endtask

   task automatic test_nr14();
      int n;
      out_ready14 = 1'b0;
      @(negedge clk);
      in_valid14 = 1'b1;
      in_data14  = CT14;
      checks++;
      if ({in_ready14, rk_idx14} !== {1'b1, 4'd14}) begin
         failures++;
         $display("FAIL c3_accept got=%b exp=%b", {in_ready14, rk_idx14}, {1'b1, 4'd14});
      end
      @(negedge clk);
      in_valid14 = 1'b0;
      n = 0;
      while (!out_valid14 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n !== 14) begin
         failures++;
         $display("FAIL c3_latency got=%0d exp=14", n);
      end
      checks++;
      if (out_data14 !== PT) begin
         failures++;
         $display("FAIL c3_plaintext got=%h exp=%h", out_data14, PT);
      end
      out_ready14 = 1'b1;
      @(negedge clk);
      out_ready14 = 1'b0;
   endtask

   task automatic test_hold_done();
      int n;
      out_ready10 = 1'b0;
      @(negedge clk);
      in_valid10 = 1'b1;
      in_data10  = CT10;
      @(negedge clk);
      in_valid10 = 1'b0;
      n = 0;
      while (!out_valid10 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n !== 10) begin
         failures++;
         $display("FAIL hold_latency got=%0d exp=10", n);
      end
      for (int i = 0; i < 5; i++) begin
         if (i == 1) begin
            in_valid10 = 1'b1;
            in_data10  = ~CT10;
         end
         if (i == 3) in_valid10 = 1'b0;
         checks++;
         if ({out_valid10, in_ready10, out_data10} !== {1'b1, 1'b0, PT}) begin
            failures++;
            $display("FAIL hold_stable got=%b/%h exp=10/%h", {out_valid10, in_ready10}, out_data10, PT);
         end
         @(negedge clk);
      end
      in_valid10  = 1'b0;
      out_ready10 = 1'b1;
      @(negedge clk);
      out_ready10 = 1'b0;
      checks++;
      if ({busy10, in_ready10, out_valid10} !== 3'b010) begin
         failures++;
         $display("FAIL hold_release got=%b exp=010", {busy10, in_ready10, out_valid10});
      end
      @(negedge clk);
      checks++;
      if (busy10 !== 1'b0) begin
         failures++;
         $display("FAIL hold_ignored_input got=%b exp=0", busy10);
      end
   endtask

   task automatic test_back_to_back();
      int           n;
      logic         seen;
      logic [127:0] pt1;
      out_ready10 = 1'b1;
      @(negedge clk);
      in_valid10 = 1'b1;
      in_data10  = CT10;
      checks++;
      if (in_ready10 !== 1'b1) begin
         failures++;
         $display("FAIL b2b_first_ready got=%b exp=1", in_ready10);
      end
      n    = 0;
      seen = 1'b0;
      pt1  = '0;
      do begin
         @(negedge clk);
         n++;
         if (out_valid10) begin
            pt1  = out_data10;
            seen = 1'b1;
         end
      end while (!in_ready10 && n < 40);
      checks++;
      if (n !== 12) begin
         failures++;
         $display("FAIL b2b_spacing got=%0d exp=12", n);
      end
      checks++;
      if ({seen, pt1} !== {1'b1, PT}) begin
         failures++;
         $display("FAIL b2b_first_pt got=%b/%h exp=1/%h", seen, pt1, PT);
      end
      @(negedge clk);
      in_valid10 = 1'b0;
      checks++;
      if (busy10 !== 1'b1) begin
         failures++;
         $display("FAIL b2b_second_accept got=%b exp=1", busy10);
      end
      n = 0;
      while (!out_valid10 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if ({n[7:0], out_data10} !== {8'd10, PT}) begin
         failures++;
         $display("FAIL b2b_second_pt got=%0d/%h exp=10/%h", n, out_data10, PT);
      end
      @(negedge clk);
      out_ready10 = 1'b0;
      checks++;
      if (in_ready10 !== 1'b1) begin
         failures++;
         $display("FAIL b2b_idle got=%b exp=1", in_ready10);
      end
   endtask

   task automatic test_reset_midblock();
      int n;
      int pulses;
      out_ready10 = 1'b0;
      @(negedge clk);
      in_valid10 = 1'b1;
      in_data10  = CT10;
      @(negedge clk);
      in_valid10 = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if ({busy10, rk_idx10} !== {1'b1, 4'd5}) begin
         failures++;
         $display("FAIL mid_round5 got=%b exp=%b", {busy10, rk_idx10}, {1'b1, 4'd5});
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({in_ready10, out_valid10, busy10, rk_idx10} !== {1'b1, 1'b0, 1'b0, 4'd10}) begin
         failures++;
         $display("FAIL mid_reset_ctrl got=%b exp=%b", {in_ready10, out_valid10, busy10, rk_idx10}, {1'b1, 1'b0, 1'b0, 4'd10});
      end
      checks++;
      if (out_data10 !== 128'h0) begin
         failures++;
         $display("FAIL mid_reset_data got=%h exp=0", out_data10);
      end
      pulses = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (out_valid10) pulses++;
      end
      checks++;
      if (pulses !== 0) begin
         failures++;
         $display("FAIL mid_no_output got=%0d exp=0", pulses);
      end
      in_valid10 = 1'b1;
      in_data10  = CT10;
      @(negedge clk);
      in_valid10 = 1'b0;
      n = 0;
      while (!out_valid10 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if ({n[7:0], out_data10} !== {8'd10, PT}) begin
         failures++;
         $display("FAIL mid_after_reset got=%0d/%h exp=10/%h", n, out_data10, PT);
      end
      out_ready10 = 1'b1;
      @(negedge clk);
      out_ready10 = 1'b0;
   endtask

   initial begin
      for (int r = 0; r < 16; r++) begin
         rks10[r] = (r <= 10) ? round_key(K128, 4, r) : 128'h0;
         rks14[r] = (r <= 14) ? round_key(K256, 8, r) : 128'h0;
      end
      rst         = 1'b1;
      in_valid10  = 1'b0;
      in_data10   = '0;
      out_ready10 = 1'b0;
      in_valid14  = 1'b0;
      in_data14   = '0;
      out_ready14 = 1'b0;
      test_reset();
      test_c1_trace();
      test_nr14();
      test_hold_done();
      test_back_to_back();
      test_reset_midblock();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
